// File: rtl/frame_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_pkg : frame geometry, sync word and receiver state type | rev 1.0
// ---------------------------------------------------------------------------
package frame_pkg;

  localparam int         FRAME_W   = 12;
  localparam logic [5:0] SYNC      = 6'b100_010;

  localparam int         A_HI_MSB  = 11;
  localparam int         A_HI_LSB  = 10;
  localparam int         B_REP_MSB = 9;
  localparam int         B_REP_LSB = 7;
  localparam int         A_LO      = 6;
  localparam int         SYNC_MSB  = 5;
  localparam int         SYNC_LSB  = 0;

  localparam logic [3:0] LAST_BIT  = 4'd11;
  localparam logic [3:0] FILL_MAX  = 4'd12;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } fu_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_unpacker_maj3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maj3 : 3-input majority vote with disagreement flag | rev 1.0
// ---------------------------------------------------------------------------
module maj3 (
  input  logic [2:0] bits_i,
  output logic       maj_o,
  output logic       disagree_o
);

  assign maj_o      = (bits_i[0] & bits_i[1]) | (bits_i[0] & bits_i[2]) | (bits_i[1] & bits_i[2]);
  assign disagree_o = ~((&bits_i) | ~(|bits_i));

endmodule
`default_nettype wire

// File: rtl/frame_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_unpacker : serial frame hunter/locker with 1-entry valid/ready output | rev 1.0
// ---------------------------------------------------------------------------
module frame_unpacker
  import frame_pkg::*;
#(
  parameter int MISS_LIMIT = 2,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_a,
  output logic              out_b,
  output logic              out_rep_err,
  output logic              locked,
  output logic [DROP_W-1:0] drop_cnt
);

  // Miss counter only needs to reach MISS_LIMIT-1 before the fallback fires.
  localparam int              MISS_W    = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  fu_state_t           state_q;
  logic [FRAME_W-1:0]  sr_q;
  logic [3:0]          fill_q;
  logic [3:0]          phase_q;
  logic [MISS_W-1:0]   miss_q;
  logic                out_valid_q;
  logic [2:0]          out_a_q;
  logic                out_b_q;
  logic                out_rep_err_q;
  logic [DROP_W-1:0]   drop_q;

  logic [FRAME_W-1:0]  sr_d;
  logic                sync_ok;
  logic                hunt_hit;
  logic                lock_end;
  logic                deliver;
  logic                load;
  logic                maj;
  logic                disagree;

  assign sr_d     = {sr_q[FRAME_W-2:0], bit_in};
  assign sync_ok  = (sr_d[SYNC_MSB:SYNC_LSB] == SYNC);
  assign hunt_hit = bit_valid && (state_q == HUNT) && (fill_q >= 4'd11) && sync_ok;
  assign lock_end = bit_valid && (state_q == LOCKED) && (phase_q == LAST_BIT);
  assign deliver  = hunt_hit || (lock_end && sync_ok);
  assign load     = deliver && (!out_valid_q || out_ready);

  maj3 u_maj3 (
    .bits_i     (sr_d[B_REP_MSB:B_REP_LSB]),
    .maj_o      (maj),
    .disagree_o (disagree)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      fill_q        <= '0;
      phase_q       <= '0;
      miss_q        <= '0;
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= 1'b0;
      out_rep_err_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      if (bit_valid) begin
        sr_q <= sr_d;
        if (fill_q != FILL_MAX) fill_q <= fill_q + 4'd1;
      end

      case (state_q)
        HUNT: begin
          if (hunt_hit) begin
            state_q <= LOCKED;
            phase_q <= '0;
            miss_q  <= '0;
          end
        end
        LOCKED: begin
          if (bit_valid) begin
            if (phase_q == LAST_BIT) begin
              phase_q <= '0;
              if (sync_ok) begin
                miss_q <= '0;
              end else if (miss_q == MISS_LAST) begin
                // Shift register and fill are kept so the hunt resumes on live bits.
                state_q <= HUNT;
                miss_q  <= '0;
              end else begin
                miss_q <= miss_q + MISS_W'(1);
              end
            end else begin
              phase_q <= phase_q + 4'd1;
            end
          end
        end
        default: state_q <= HUNT;
      endcase

      if (load) begin
        out_valid_q   <= 1'b1;
        out_a_q       <= {sr_d[A_HI_MSB:A_HI_LSB], sr_d[A_LO]};
        out_b_q       <= maj;
        out_rep_err_q <= disagree;
      end else begin
        if (deliver && !(&drop_q)) drop_q <= drop_q + DROP_W'(1);
        if (out_ready) out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_rep_err = out_rep_err_q;
  assign locked      = (state_q == LOCKED);
  assign drop_cnt    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frame_unpacker : directed + randomized bench with behavioural model | rev 1.0
// ---------------------------------------------------------------------------
module tb_frame_unpacker;

  localparam int MISS_LIMIT = 2;
  localparam int DROP_W     = 8;
  localparam int DROP_MAX   = (1 << DROP_W) - 1;

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              bit_in    = 1'b0;
  logic              bit_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [2:0]        out_a;
  logic              out_b;
  logic              out_rep_err;
  logic              locked;
  logic [DROP_W-1:0] drop_cnt;

  int n_chk   = 0;
  int n_bad   = 0;
  bit started = 1'b0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  frame_unpacker #(.MISS_LIMIT(MISS_LIMIT), .DROP_W(DROP_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_rep_err (out_rep_err),
    .locked      (locked),
    .drop_cnt    (drop_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a 12-bit window of received bits, a lock flag and a
  // count of bits since the last frame boundary.
  bit [11:0] m_win;
  int        m_fill, m_since, m_miss, m_drop;
  bit        m_lock, m_ov, m_b, m_err, m_have;
  bit [2:0]  m_a;
  int        m_votes;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_win = '0; m_fill = 0; m_since = 0; m_miss = 0; m_drop = 0;
      m_lock = 0; m_ov = 0; m_b = 0; m_err = 0; m_a = '0;
    end else begin
      m_have = 0;
      if (bit_valid) begin
        m_win = {m_win[10:0], bit_in};
        if (m_fill < 12) m_fill++;
        if (!m_lock) begin
          if (m_fill == 12 && m_win[5:0] == 6'b100010) begin
            m_have = 1; m_lock = 1; m_since = 0; m_miss = 0;
          end
        end else begin
          m_since++;
          if (m_since == 12) begin
            m_since = 0;
            if (m_win[5:0] == 6'b100010) begin
              m_have = 1; m_miss = 0;
            end else begin
              m_miss++;
              if (m_miss == MISS_LIMIT) begin m_lock = 0; m_miss = 0; end
            end
          end
        end
      end
      if (m_have && (!m_ov || out_ready)) begin
        m_ov    = 1;
        m_a     = {m_win[11:10], m_win[6]};
        m_votes = int'(m_win[9]) + int'(m_win[8]) + int'(m_win[7]);
        m_b     = (m_votes >= 2);
        m_err   = (m_votes != 0) && (m_votes != 3);
      end else if (m_have) begin
        if (m_drop < DROP_MAX) m_drop++;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_out_valid", out_valid, m_ov);
      chk("cyc_locked", locked, m_lock);
      chk("cyc_drop_cnt", drop_cnt, m_drop);
      if (m_ov) begin
        chk("cyc_out_a", out_a, m_a);
        chk("cyc_out_b", out_b, m_b);
        chk("cyc_out_rep_err", out_rep_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input bit b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] f, input int max_gap);
    for (int i = 11; i >= 0; i--) begin
      idle($urandom_range(max_gap));
      send_bit(f[i]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  logic [11:0] fa2 = 12'hFA2;
  logic [11:0] rf;
  int          r;

  initial begin
    reset_n = 1'b0;
    idle(2);
    started = 1'b1;
    reset_n = 1'b1;
    idle(1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // First frame from reset: valid only after the 12th bit
    out_ready = 1'b1;
    for (int i = 11; i >= 1; i--) send_bit(fa2[i]);
    chk("t1_early_valid", out_valid, 0);
    send_bit(fa2[0]);
    chk("t1_valid", out_valid, 1);
    chk("t1_a", out_a, 3'b110);
    chk("t1_b", out_b, 1);
    chk("t1_err", out_rep_err, 0);
    chk("t1_locked", locked, 1);
    idle(1);
    chk("t1_valid_fall", out_valid, 0);

    // Disagreeing b copies, idle gaps between bits
    send_frame(12'hEA2, 2);
    chk("t2_valid", out_valid, 1);
    chk("t2_a", out_a, 3'b110);
    chk("t2_b", out_b, 1);
    chk("t2_err", out_rep_err, 1);

    // Leading garbage delays the lock
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    for (int i = 11; i >= 1; i--) send_bit(fa2[i]);
    chk("t3_early_valid", out_valid, 0);
    chk("t3_early_locked", locked, 0);
    send_bit(fa2[0]);
    chk("t3_valid", out_valid, 1);
    chk("t3_locked", locked, 1);

    // Back-pressure: second frame dropped, first held
    idle(1);
    out_ready = 1'b0;
    send_frame(12'hFA2, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_a", out_a, 3'b110);
    send_frame(12'h022, 1);
    chk("t4_held_valid", out_valid, 1);
    chk("t4_held_a", out_a, 3'b110);
    chk("t4_held_b", out_b, 1);
    chk("t4_drop", drop_cnt, 1);
    out_ready = 1'b1;
    tick();
    chk("t4_valid_fall", out_valid, 0);

    // Two bad-sync frames drop lock, a good frame relocks
    send_frame(12'hFC0, 0);
    chk("t5_no_deliver", out_valid, 0);
    chk("t5_still_locked", locked, 1);
    send_frame(12'hFC0, 0);
    chk("t5_unlocked", locked, 0);
    chk("t5_no_deliver2", out_valid, 0);
    send_frame(12'hFA2, 0);
    chk("t5_relocked", locked, 1);
    chk("t5_valid", out_valid, 1);
    chk("t5_a", out_a, 3'b110);

    // Reset mid-frame while holding an undelivered frame
    out_ready = 1'b0;
    for (int i = 11; i >= 6; i--) send_bit(fa2[i]);
    reset_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_a", out_a, 0);
    chk("t6_b", out_b, 0);
    chk("t6_err", out_rep_err, 0);
    chk("t6_locked", locked, 0);
    chk("t6_drop", drop_cnt, 0);
    idle(2);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 11; i >= 1; i--) send_bit(fa2[i]);
    chk("t6_early_valid", out_valid, 0);
    send_bit(fa2[0]);
    chk("t6_valid_after", out_valid, 1);
    chk("t6_a_after", out_a, 3'b110);

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(99);
      if (r < 60) begin
        rf = 12'($urandom);
        rf[5:0] = 6'b100010;
        if (r < 40) rf[9:7] = rf[9] ? 3'b111 : 3'b000;
        send_frame(rf, 2);
      end else if (r < 80) begin
        send_frame(12'($urandom), 2);
      end else begin
        for (int j = 0; j < int'($urandom_range(5, 1)); j++) send_bit(1'($urandom));
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    idle(2);

    // Drop counter saturation
    do_reset();
    send_frame(12'hFA2, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 260; k++) send_frame(12'hFA2, 0);
    chk("sat_drop", drop_cnt, DROP_MAX);
    chk("sat_valid", out_valid, 1);
    chk("sat_locked", locked, 1);
    out_ready = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
